// File: rtl/vga_scanout.sv
// vga_scanout: parametrised VGA scan-out engine.
//
// A divider turns mclk into a pixel tick. The horizontal and vertical counters advance on
// each tick, and a three-stage pipeline clocked by the tick produces the pixel:
//   stage 0  VRAM byte address plus pixel index
//   stage 1  capture the byte and unpack one pixel (LSB-first)
//   stage 2  colour map to RGB332, with registered syncs and vidon
// Sync and vidon travel through the same stages as the pixel, so they stay aligned with it.
//
// Ports:
//   mclk, resetn          system clock; asynchronous active-low reset
//   vram_addr[ADDR_W]     registered display read address
//   vram_data[8]          read data, valid one mclk after vram_addr changes
//   hsync, vsync          active-low syncs
//   vidon                 output pixel is in the active area
//   red[3] green[3] blue[2]
//   frame_start           one-mclk pulse when the outputs show pixel (0,0)
//
// Optional build macro CURSOR_EN adds cursor_x[10], cursor_y[10] and cursor_on. These are
// shadowed at frame_start and invert an 8x8 block of active pixels.

module vga_scanout #(
  parameter int unsigned H_ACT     = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACT     = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned BPP       = 1,
  parameter int unsigned SCALE     = 1,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              mclk,
  input  logic              resetn,
`ifdef CURSOR_EN
  input  logic [9:0]        cursor_x,
  input  logic [9:0]        cursor_y,
  input  logic              cursor_on,
`endif
  output logic [ADDR_W-1:0] vram_addr,
  input  logic [7:0]        vram_data,
  output logic              hsync,
  output logic              vsync,
  output logic              vidon,
  output logic [2:0]        red,
  output logic [2:0]        green,
  output logic [1:0]        blue,
  output logic              frame_start
);

  localparam int unsigned H_TOT  = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT  = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int unsigned PPW    = 8 / BPP;
  localparam int unsigned PPW_SH = $clog2(PPW);
  localparam int unsigned SC_SH  = (SCALE == 2) ? 1 : 0;
  localparam int unsigned WPL    = H_ACT / (SCALE * PPW);  // VRAM bytes per source line
  localparam int unsigned HW     = $clog2(H_TOT);
  localparam int unsigned VW     = $clog2(V_TOT);
  localparam int unsigned DW     = $clog2(CLK_DIV);
  localparam int unsigned PW     = (PPW_SH == 0) ? 1 : PPW_SH;

  localparam logic [DW-1:0]     DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0]     H_LAST   = HW'(H_TOT - 1);
  localparam logic [HW-1:0]     H_ACT_C  = HW'(H_ACT);
  localparam logic [HW-1:0]     HS_BEG   = HW'(H_ACT + H_FP);
  localparam logic [HW-1:0]     HS_END   = HW'(H_ACT + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0]     V_LAST   = VW'(V_TOT - 1);
  localparam logic [VW-1:0]     V_ACT_C  = VW'(V_ACT);
  localparam logic [VW-1:0]     VS_BEG   = VW'(V_ACT + V_FP);
  localparam logic [VW-1:0]     VS_END   = VW'(V_ACT + V_FP + V_SYNC - 1);
  localparam logic [ADDR_W-1:0] BASE_C   = ADDR_W'(BASE_ADDR);

  // Tick divider and raster counters
  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] hc_q, hc_d;
  logic [VW-1:0] vc_q, vc_d;
  logic          tick;

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    div_d = tick ? '0 : div_q + 1'b1;
    hc_d  = hc_q;
    vc_d  = vc_q;
    if (tick) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
      end else begin
        hc_d = hc_q + 1'b1;
      end
    end
  end

  // Stage 0 next-state values
  logic [HW-1:0]     hc_sc;
  logic [VW-1:0]     vc_sc;
  logic              act0_d, hs0_d, vs0_d, first0_d;
  logic [ADDR_W-1:0] addr_d;
  logic [PW-1:0]     p0_d;

  always_comb begin
    hc_sc    = hc_q >> SC_SH;
    vc_sc    = vc_q >> SC_SH;
    act0_d   = (hc_q < H_ACT_C) && (vc_q < V_ACT_C);
    hs0_d    = !((hc_q >= HS_BEG) && (hc_q <= HS_END));
    vs0_d    = !((vc_q >= VS_BEG) && (vc_q <= VS_END));
    first0_d = (hc_q == '0) && (vc_q == '0);
    p0_d     = (PPW == 1) ? '0 : PW'(hc_sc);
    // Sum is taken at 32 bits and truncated, so it wraps at ADDR_W.
    addr_d   = BASE_C;
    if (act0_d) begin
      addr_d = ADDR_W'(BASE_ADDR + 32'(vc_sc) * WPL + (32'(hc_sc) >> PPW_SH));
    end
  end

  // Pipeline registers
  logic [ADDR_W-1:0] addr_q;
  logic [PW-1:0]     p0_q;
  logic              act0_q, hs0_q, vs0_q, first0_q;
  logic [7:0]        pix1_q, pix1_d;
  logic              act1_q, hs1_q, vs1_q, first1_q;
  logic [7:0]        rgb_q, rgb_d;
  logic              vid_q, hs_q, vs_q, fs_q;

  // Stage 1: select one BPP-wide field of the fetched byte; pixel 0 is in the low bits.
  always_comb begin
    pix1_d = '0;
    for (int i = 0; i < PPW; i++) begin
      if (PW'(i) == p0_q) begin
        pix1_d[BPP-1:0] = vram_data[i*BPP +: BPP];
      end
    end
  end

  function automatic logic [7:0] color_map(input logic [7:0] p);
    logic [7:0] c;
    if (BPP == 1) begin
      c = {8{p[0]}};
    end else if (BPP == 2) begin
      c = {p[1:0], p[1], p[1:0], p[1], p[1:0]};
    end else if (BPP == 4) begin
      // p = {I, R, G, B}
      c = {p[2], p[2], p[3], p[1], p[1], p[3], p[0], p[3]};
    end else begin
      c = p;
    end
    return c;
  endfunction

`ifdef CURSOR_EN
  // Cursor shadows and hit flag, delayed alongside the pixel
  logic [9:0] cx_q, cy_q;
  logic       con_q;
  logic       cur0_d, cur0_q, cur1_q;

  always_comb begin
    cur0_d = con_q &&
             (16'(hc_q) >= {6'd0, cx_q}) && (16'(hc_q) <= {6'd0, cx_q} + 16'd7) &&
             (16'(vc_q) >= {6'd0, cy_q}) && (16'(vc_q) <= {6'd0, cy_q} + 16'd7);
  end

  always_ff @(posedge mclk or negedge resetn) begin
    if (!resetn) begin
      cx_q   <= '0;
      cy_q   <= '0;
      con_q  <= 1'b0;
      cur0_q <= 1'b0;
      cur1_q <= 1'b0;
    end else begin
      if (tick && first1_q) begin
        cx_q  <= cursor_x;
        cy_q  <= cursor_y;
        con_q <= cursor_on;
      end
      if (tick) begin
        cur0_q <= cur0_d;
        cur1_q <= cur0_q;
      end
    end
  end
`endif

  always_comb begin
    rgb_d = act1_q ? color_map(pix1_q) : 8'h00;
`ifdef CURSOR_EN
    if (act1_q && cur1_q) begin
      rgb_d = ~rgb_d;
    end
`endif
  end

  always_ff @(posedge mclk or negedge resetn) begin
    if (!resetn) begin
      div_q    <= '0;
      hc_q     <= '0;
      vc_q     <= '0;
      addr_q   <= BASE_C;
      p0_q     <= '0;
      act0_q   <= 1'b0;
      hs0_q    <= 1'b1;
      vs0_q    <= 1'b1;
      first0_q <= 1'b0;
      pix1_q   <= '0;
      act1_q   <= 1'b0;
      hs1_q    <= 1'b1;
      vs1_q    <= 1'b1;
      first1_q <= 1'b0;
      rgb_q    <= '0;
      vid_q    <= 1'b0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      fs_q     <= 1'b0;
    end else begin
      div_q <= div_d;
      hc_q  <= hc_d;
      vc_q  <= vc_d;
      // Registered every mclk so the pulse lasts exactly one cycle.
      fs_q  <= tick && first1_q;
      if (tick) begin
        addr_q   <= addr_d;
        p0_q     <= p0_d;
        act0_q   <= act0_d;
        hs0_q    <= hs0_d;
        vs0_q    <= vs0_d;
        first0_q <= first0_d;
        pix1_q   <= pix1_d;
        act1_q   <= act0_q;
        hs1_q    <= hs0_q;
        vs1_q    <= vs0_q;
        first1_q <= first0_q;
        rgb_q    <= rgb_d;
        vid_q    <= act1_q;
        hs_q     <= hs1_q;
        vs_q     <= vs1_q;
      end
    end
  end

  assign vram_addr   = addr_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign vidon       = vid_q;
  assign red         = rgb_q[7:5];
  assign green       = rgb_q[4:2];
  assign blue        = rgb_q[1:0];
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_scanout.sv
module tb_vga_scanout;

  // Reduced timing keeps a full frame short: H_TOT = 40, V_TOT = 12, frame = 480 ticks.
  localparam int H_ACT = 32, H_FP = 2, H_SYNC = 4, H_BP = 2;
  localparam int V_ACT = 8, V_FP = 1, V_SYNC = 2, V_BP = 1;
  localparam int H_TOT = 40;
  localparam int V_TOT = 12;
  localparam int FRAME = 480;
  localparam int CDIV  = 4;

  logic mclk = 1'b0;
  logic resetn = 1'b0;
  always #5 mclk = ~mclk;

  logic [15:0] addr_a, addr_b, addr_c;
  logic [7:0]  data_a, data_b, data_c;
  logic        hs_a, vs_a, vid_a, fs_a;
  logic        hs_b, vs_b, vid_b, fs_b;
  logic        hs_c, vs_c, vid_c, fs_c;
  logic [2:0]  r_a, g_a, r_b, g_b, r_c, g_c;
  logic [1:0]  b_a, b_b, b_c;
  logic [7:0]  rgb_a, rgb_b, rgb_c;
  assign rgb_a = {r_a, g_a, b_a};
  assign rgb_b = {r_b, g_b, b_b};
  assign rgb_c = {r_c, g_c, b_c};

`ifdef CURSOR_EN
  logic [9:0] cur_x = '0, cur_y = '0;
  logic       cur_on = 1'b0;
`endif

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic [7:0] mem_c [256];
  always @(posedge mclk) begin
    data_a <= mem_a[addr_a[7:0]];
    data_b <= mem_b[addr_b[7:0]];
    data_c <= mem_c[addr_c[7:0]];
  end

  // mclk edges since the last reset release
  int cyc;
  always @(posedge mclk or negedge resetn) begin
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  vga_scanout #(.H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP), .V_ACT(V_ACT),
    .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .CLK_DIV(CDIV), .BPP(1), .SCALE(1))
  u_a (.mclk(mclk), .resetn(resetn),
`ifdef CURSOR_EN
    .cursor_x(cur_x), .cursor_y(cur_y), .cursor_on(cur_on),
`endif
    .vram_addr(addr_a), .vram_data(data_a), .hsync(hs_a), .vsync(vs_a), .vidon(vid_a),
    .red(r_a), .green(g_a), .blue(b_a), .frame_start(fs_a));

  vga_scanout #(.H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP), .V_ACT(V_ACT),
    .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .CLK_DIV(CDIV), .BPP(8), .SCALE(2))
  u_b (.mclk(mclk), .resetn(resetn),
`ifdef CURSOR_EN
    .cursor_x(cur_x), .cursor_y(cur_y), .cursor_on(cur_on),
`endif
    .vram_addr(addr_b), .vram_data(data_b), .hsync(hs_b), .vsync(vs_b), .vidon(vid_b),
    .red(r_b), .green(g_b), .blue(b_b), .frame_start(fs_b));

  vga_scanout #(.H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP), .V_ACT(V_ACT),
    .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .CLK_DIV(CDIV), .BPP(4), .SCALE(1))
  u_c (.mclk(mclk), .resetn(resetn),
`ifdef CURSOR_EN
    .cursor_x(cur_x), .cursor_y(cur_y), .cursor_on(cur_on),
`endif
    .vram_addr(addr_c), .vram_data(data_c), .hsync(hs_c), .vsync(vs_c), .vidon(vid_c),
    .red(r_c), .green(g_c), .blue(b_c), .frame_start(fs_c));

  int checks = 0;
  int passes = 0;

  // Output pixel q (q = vc*H_TOT + hc) is shown after mclk edge CDIV*(q+3);
  // the stage-0 address of position q appears after edge CDIV*(q+1).
  function automatic int out_cyc(input int q);
    return CDIV * (q + 3);
  endfunction
  function automatic int addr_cyc(input int q);
    return CDIV * (q + 1);
  endfunction

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge mclk);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (10) @(posedge mclk);
    @(negedge mclk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (10) @(posedge mclk);
    @(negedge mclk);
    checks++;
    if ({hs_a, vs_a, vid_a, rgb_a, fs_a} !== {1'b1, 1'b1, 1'b0, 8'h00, 1'b0})
      $display("FAIL reset_outputs: got %b want %b", {hs_a, vs_a, vid_a, rgb_a, fs_a},
               {1'b1, 1'b1, 1'b0, 8'h00, 1'b0});
    else passes++;
    checks++;
    if (addr_a !== 16'h0) $display("FAIL reset_addr: got %h want 0000", addr_a);
    else passes++;
    resetn = 1'b1;
    wait_cyc(3);
    checks++;
    if ({hs_a, vs_a, vid_a, rgb_a, fs_a} !== {1'b1, 1'b1, 1'b0, 8'h00, 1'b0})
      $display("FAIL pre_tick_outputs: got %b", {hs_a, vs_a, vid_a, rgb_a, fs_a});
    else passes++;
    wait_cyc(11);
    checks++;
    if ({vid_a, fs_a, addr_c} !== {1'b0, 1'b0, 16'h0000})
      $display("FAIL fill_cyc11: got vid=%b fs=%b addr_c=%h want 0 0 0000", vid_a, fs_a, addr_c);
    else passes++;
    wait_cyc(12);
    checks++;
    if ({vid_a, fs_a, addr_c} !== {1'b1, 1'b1, 16'h0001})
      $display("FAIL first_pixel_cyc12: got vid=%b fs=%b addr_c=%h want 1 1 0001",
               vid_a, fs_a, addr_c);
    else passes++;
    wait_cyc(13);
    checks++;
    if (fs_a !== 1'b0) $display("FAIL fs_one_cycle: got %b want 0", fs_a);
    else passes++;
  endtask

  task automatic test_frame();
    int hs_lo = 0, vs_lo = 0, vid_hi = 0, fs_cnt = 0, pos_err = 0, hold_err = 0;
    logic [10:0] snap;
    do_reset();
    for (int q = 0; q < FRAME; q++) begin
      int h, v;
      logic ehs, evs, evid;
      h = q % H_TOT;
      v = q / H_TOT;
      ehs  = !(h >= 34 && h <= 37);
      evs  = !(v >= 9 && v <= 10);
      evid = (h < 32) && (v < 8);
      wait_cyc(out_cyc(q));
      if (!hs_a) hs_lo++;
      if (!vs_a) vs_lo++;
      if (vid_a) vid_hi++;
      if (fs_a) fs_cnt++;
      if ({hs_a, vs_a, vid_a} !== {ehs, evs, evid}) pos_err++;
      snap = {hs_a, vs_a, vid_a, rgb_a};
      wait_cyc(out_cyc(q) + 2);
      if ({hs_a, vs_a, vid_a, rgb_a} !== snap) hold_err++;
    end
    checks++;
    if (hs_lo !== 48) $display("FAIL hsync_low_ticks: got %0d want 48", hs_lo); else passes++;
    checks++;
    if (vs_lo !== 80) $display("FAIL vsync_low_ticks: got %0d want 80", vs_lo); else passes++;
    checks++;
    if (vid_hi !== 256) $display("FAIL vidon_ticks: got %0d want 256", vid_hi); else passes++;
    checks++;
    if (pos_err !== 0) $display("FAIL sync_positions: got %0d errors want 0", pos_err);
    else passes++;
    checks++;
    if (hold_err !== 0) $display("FAIL hold_between_ticks: got %0d errors want 0", hold_err);
    else passes++;
    checks++;
    if (fs_cnt !== 1) $display("FAIL frame_start_count: got %0d want 1", fs_cnt); else passes++;
    wait_cyc(out_cyc(FRAME));
    checks++;
    if ({fs_a, vid_a} !== 2'b11) $display("FAIL next_frame_start: got %b want 11", {fs_a, vid_a});
    else passes++;
  endtask

  task automatic test_bpp1();
    do_reset();
    for (int q = 0; q < 8; q++) begin
      logic [7:0] exp_rgb;
      exp_rgb = (q == 0) ? 8'hFF : 8'h00;
      wait_cyc(out_cyc(q));
      checks++;
      if (rgb_a !== exp_rgb) $display("FAIL bpp1_pixel%0d: got %h want %h", q, rgb_a, exp_rgb);
      else passes++;
    end
    wait_cyc(addr_cyc(8));
    checks++;
    if (addr_a !== 16'd1) $display("FAIL bpp1_addr_px8: got %0d want 1", addr_a); else passes++;
    wait_cyc(addr_cyc(H_TOT));
    checks++;
    if (addr_a !== 16'd4) $display("FAIL bpp1_addr_line1: got %0d want 4", addr_a); else passes++;
    wait_cyc(out_cyc(H_TOT));
    checks++;
    if (rgb_a !== 8'h00) $display("FAIL bpp1_line1_px0: got %h want 00", rgb_a); else passes++;
    wait_cyc(out_cyc(H_TOT + 1));
    checks++;
    if (rgb_a !== 8'hFF) $display("FAIL bpp1_line1_px1: got %h want ff", rgb_a); else passes++;
  endtask

  task automatic test_bpp8_scale2();
    int qs[5] = '{0, 1, 2, 40, 41};
    logic [7:0] ex[5] = '{8'hE0, 8'hE0, 8'h1C, 8'hE0, 8'hE0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wait_cyc(out_cyc(qs[i]));
      checks++;
      if ({r_b, g_b, b_b} !== ex[i] || vid_b !== 1'b1)
        $display("FAIL bpp8_q%0d: got rgb=%h vid=%b want %h 1", qs[i], rgb_b, vid_b, ex[i]);
      else passes++;
    end
    wait_cyc(addr_cyc(2 * H_TOT));
    checks++;
    if (addr_b !== 16'd16) $display("FAIL bpp8_addr_line2: got %0d want 16", addr_b);
    else passes++;
    wait_cyc(out_cyc(2 * H_TOT));
    checks++;
    if (rgb_b !== 8'h03) $display("FAIL bpp8_line2_px0: got %h want 03", rgb_b); else passes++;
  endtask

  task automatic test_bpp4();
    do_reset();
    wait_cyc(out_cyc(0));
    checks++;
    if (rgb_c !== 8'hC2) $display("FAIL bpp4_px0: got %h want c2", rgb_c); else passes++;
    wait_cyc(out_cyc(1));
    checks++;
    if (rgb_c !== 8'h3D) $display("FAIL bpp4_px1: got %h want 3d", rgb_c); else passes++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    wait_cyc(out_cyc(5 * H_TOT + 20) + 1);
    checks++;
    if ({vid_a, (addr_a != 16'h0)} !== 2'b11)
      $display("FAIL pre_reset_state: got vid=%b addr=%h want 1 nonzero", vid_a, addr_a);
    else passes++;
    resetn = 1'b0;
    #1;
    checks++;
    if ({hs_a, vs_a, vid_a, rgb_a, fs_a, addr_a} !== {3'b110, 8'h00, 1'b0, 16'h0000})
      $display("FAIL async_reset: got %b", {hs_a, vs_a, vid_a, rgb_a, fs_a, addr_a});
    else passes++;
    repeat (3) @(posedge mclk);
    @(negedge mclk);
    resetn = 1'b1;
    wait_cyc(11);
    checks++;
    if (fs_a !== 1'b0) $display("FAIL restart_fs_early: got %b want 0", fs_a); else passes++;
    wait_cyc(12);
    checks++;
    if ({fs_a, vid_a} !== 2'b11) $display("FAIL restart_fs_px00: got %b want 11", {fs_a, vid_a});
    else passes++;
    wait_cyc(out_cyc(33));
    checks++;
    if (hs_a !== 1'b1) $display("FAIL restart_hs_q33: got %b want 1", hs_a); else passes++;
    wait_cyc(out_cyc(34));
    checks++;
    if (hs_a !== 1'b0) $display("FAIL restart_hs_q34: got %b want 0", hs_a); else passes++;
    wait_cyc(out_cyc(359));
    checks++;
    if (vs_a !== 1'b1) $display("FAIL restart_vs_line8: got %b want 1", vs_a); else passes++;
    wait_cyc(out_cyc(360));
    checks++;
    if (vs_a !== 1'b0) $display("FAIL restart_vs_line9: got %b want 0", vs_a); else passes++;
  endtask

`ifdef CURSOR_EN
  task automatic test_cursor();
    int qs[7] = '{48, 87, 88, 96, 200, 295, FRAME + 200};
    logic [7:0] ex[7] = '{8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF};
    for (int i = 0; i < 256; i++) mem_a[i] = 8'h00;
    cur_x = 10'd8;
    cur_y = 10'd2;
    cur_on = 1'b1;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      wait_cyc(out_cyc(qs[i]));
      checks++;
      if (rgb_a !== ex[i]) $display("FAIL cursor_q%0d: got %h want %h", qs[i], rgb_a, ex[i]);
      else passes++;
      // Move the cursor mid-frame; the shadow must keep the old position until frame_start.
      if (i == 3) begin
        cur_x = 10'd0;
        cur_y = 10'd0;
      end
    end
    wait_cyc(out_cyc(FRAME + 288));
    checks++;
    if (rgb_a !== 8'h00) $display("FAIL cursor_moved_old: got %h want 00", rgb_a); else passes++;
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 8'h00;
      mem_b[i] = 8'h00;
      mem_c[i] = 8'h00;
    end
    mem_a[0]  = 8'h01;
    mem_a[4]  = 8'h02;
    mem_b[0]  = 8'hE0;
    mem_b[1]  = 8'h1C;
    mem_b[16] = 8'h03;
    mem_c[0]  = 8'hA5;
    test_reset();
    test_frame();
    test_bpp1();
    test_bpp8_scale2();
    test_bpp4();
    test_mid_reset();
`ifdef CURSOR_EN
    test_cursor();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
